sysctrl_bank: RTL and testbench

Parametrised successor to the per-core MCU system-control block. It decodes the MCU byte-stream command protocol and holds a generic bank of `NUM_CFG` 8-bit configuration slots, addressed by slot number, instead of hard-wired per-core option registers. It latches edge-triggered interrupts with a per-channel enable mask and optionally supports config readback. The block sits between the MCU SPI byte interface and the core top level; the core slices `cfg_flat` into its option signals.

---
 rtl/sysctrl_bank.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sysctrl_bank.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysctrl_bank.sv
// sysctrl_bank
//   MCU system-control block. It decodes the MCU byte-stream command protocol
//   and holds a generic bank of NUM_CFG 8-bit configuration slots. It also
//   latches edge-triggered interrupts against a per-channel enable mask.
//
//   Optional feature macro: SYSCTRL_READBACK_EN
//     When defined, command 6 (config read) is built in.
//     When undefined, command 6 is treated as an unknown command and no
//     read mux is built.
//
//   Ports
//     clk, reset      : clock; synchronous active-high reset (also coldboot)
//     data_in_strobe  : one-cycle pulse, data_in valid
//     data_in_start   : strobe carries the command byte of a new frame
//     data_in         : MCU byte
//     data_out        : response byte, shifted out by the MCU on the next byte
//     int_out_n       : active-low interrupt request to the MCU
//     int_in          : level interrupt sources (bit 0 unused, coldboot slot)
//     buttons / leds  : board buttons in, MCU-driven LEDs out
//     color           : RGB value for the ws2812 driver
//     cfg_flat        : config bank, slot n at [8n+7:8n]
//     cfg_wr          : one-cycle pulse after each accepted slot write
//     cfg_wr_id       : slot number of the last accepted write

module sysctrl_bank #(
    parameter logic [7:0]           CORE_ID     = 8'h02,
    parameter int unsigned          NUM_CFG     = 32,
    parameter logic [NUM_CFG*8-1:0] CFG_DEFAULT = '0,
    parameter int unsigned          INT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_in_strobe,
    input  logic                   data_in_start,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   int_out_n,
    input  logic [INT_W-1:0]       int_in,
    input  logic [1:0]             buttons,
    output logic [1:0]             leds,
    output logic [23:0]            color,
    output logic [NUM_CFG*8-1:0]   cfg_flat,
    output logic                   cfg_wr,
    output logic [7:0]             cfg_wr_id
);

    localparam int unsigned CFG_W = NUM_CFG * 8;

    localparam logic [7:0] CMD_STATUS  = 8'd0;
    localparam logic [7:0] CMD_LEDS    = 8'd1;
    localparam logic [7:0] CMD_COLOR   = 8'd2;
    localparam logic [7:0] CMD_BUTTONS = 8'd3;
    localparam logic [7:0] CMD_CFG_WR  = 8'd4;
    localparam logic [7:0] CMD_INT     = 8'd5;
`ifdef SYSCTRL_READBACK_EN
    localparam logic [7:0] CMD_CFG_RD  = 8'd6;
`endif

    // Registered state
    logic [7:0]       r_cmd;
    logic [7:0]       r_idx;
    logic [7:0]       r_ptr;
    logic [7:0]       r_data_out;
    logic [1:0]       r_leds;
    logic [23:0]      r_color;
    logic [CFG_W-1:0] r_cfg;
    logic             r_cfg_wr;
    logic [7:0]       r_cfg_wr_id;
    logic [INT_W-1:0] r_pending;
    logic [INT_W-1:0] r_enable;
    logic [INT_W-1:0] r_int_q;
    logic             r_int_out_n;

    // Next-state values
    logic [7:0]       w_cmd_next;
    logic [7:0]       w_idx_next;
    logic [7:0]       w_ptr_next;
    logic [7:0]       w_data_out_next;
    logic [1:0]       w_leds_next;
    logic [23:0]      w_color_next;
    logic [CFG_W-1:0] w_cfg_next;
    logic             w_cfg_wr_next;
    logic [7:0]       w_cfg_wr_id_next;
    logic [INT_W-1:0] w_pending_next;
    logic [INT_W-1:0] w_enable_next;
    logic [INT_W-1:0] w_ack;
    logic [INT_W-1:0] w_rise;
    logic [7:0]       w_rev;
    logic             w_cmd_byte;
    logic             w_payload;
    logic             w_ptr_ok;

    // Saturating 8-bit increment shared by the byte index and slot pointer
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        logic [7:0] r;
        for (int unsigned b = 0; b < 8; b++) begin
            r[b] = v[7-b];
        end
        return r;
    endfunction

`ifdef SYSCTRL_READBACK_EN
    // Slot read mux; 9-bit address so ptr+1 past 255 reads as empty
    function automatic logic [7:0] slot_rd(input logic [CFG_W-1:0] bank,
                                           input logic [8:0]       addr);
        logic [7:0] rd;
        rd = 8'h00;
        for (int unsigned s = 0; s < NUM_CFG; s++) begin
            if (addr == 9'(s)) begin
                rd = bank[s*8 +: 8];
            end
        end
        return rd;
    endfunction
`endif

    assign w_cmd_byte = data_in_strobe && data_in_start;
    assign w_payload  = data_in_strobe && !data_in_start && (r_idx != 8'd0);
    assign w_ptr_ok   = (32'(r_ptr) < NUM_CFG);
    assign w_rev      = bit_rev(data_in);

    // Rising edges of the interrupt sources; bit 0 belongs to coldboot
    assign w_rise = int_in & ~r_int_q & ~INT_W'(1);

    // Frame decode and command execution
    always_comb begin
        w_cmd_next       = r_cmd;
        w_idx_next       = r_idx;
        w_ptr_next       = r_ptr;
        w_data_out_next  = r_data_out;
        w_leds_next      = r_leds;
        w_color_next     = r_color;
        w_cfg_next       = r_cfg;
        w_cfg_wr_next    = 1'b0;
        w_cfg_wr_id_next = r_cfg_wr_id;
        w_enable_next    = r_enable;
        w_ack            = '0;

        if (w_cmd_byte) begin
            w_cmd_next = data_in;
            w_idx_next = 8'd1;
        end else if (w_payload) begin
            w_idx_next = sat_inc(r_idx);
            case (r_cmd)
                CMD_STATUS: begin
                    case (r_idx)
                        8'd1:    w_data_out_next = 8'h5C;
                        8'd2:    w_data_out_next = 8'h42;
                        8'd3:    w_data_out_next = CORE_ID;
                        8'd4:    w_data_out_next = 8'(NUM_CFG);
                        default: w_data_out_next = 8'h00;
                    endcase
                end
                CMD_LEDS: begin
                    if (r_idx == 8'd1) begin
                        w_leds_next = data_in[1:0];
                    end
                end
                CMD_COLOR: begin
                    case (r_idx)
                        8'd1:    w_color_next[15:8]  = w_rev;
                        8'd2:    w_color_next[7:0]   = w_rev;
                        8'd3:    w_color_next[23:16] = w_rev;
                        default: ;
                    endcase
                end
                CMD_BUTTONS: begin
                    w_data_out_next = {6'b0, buttons};
                end
                CMD_CFG_WR: begin
                    if (r_idx == 8'd1) begin
                        w_ptr_next = data_in;
                    end else begin
                        w_ptr_next = sat_inc(r_ptr);
                        // Writes past the end of the bank are silently dropped
                        if (w_ptr_ok) begin
                            w_cfg_wr_next    = 1'b1;
                            w_cfg_wr_id_next = r_ptr;
                            for (int unsigned s = 0; s < NUM_CFG; s++) begin
                                if (r_ptr == 8'(s)) begin
                                    w_cfg_next[s*8 +: 8] = data_in;
                                end
                            end
                        end
                    end
                end
                CMD_INT: begin
                    w_data_out_next = 8'(r_pending);
                    if (r_idx == 8'd1) begin
                        w_ack = data_in[INT_W-1:0];
                    end
                    if (r_idx == 8'd2) begin
                        // Coldboot channel can never be masked
                        w_enable_next = data_in[INT_W-1:0] | INT_W'(1);
                    end
                end
`ifdef SYSCTRL_READBACK_EN
                CMD_CFG_RD: begin
                    if (r_idx == 8'd1) begin
                        w_ptr_next      = data_in;
                        w_data_out_next = slot_rd(r_cfg, {1'b0, data_in});
                    end else begin
                        w_ptr_next      = sat_inc(r_ptr);
                        w_data_out_next = slot_rd(r_cfg, {1'b0, r_ptr} + 9'd1);
                    end
                end
`endif
                default: ;
            endcase
        end

        // Set has priority over a same-cycle acknowledge
        w_pending_next = (r_pending & ~w_ack) | w_rise;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd       <= 8'd0;
            r_idx       <= 8'd0;
            r_ptr       <= 8'd0;
            r_data_out  <= 8'd0;
            r_leds      <= 2'd0;
            r_color     <= 24'd0;
            r_cfg       <= CFG_DEFAULT;
            r_cfg_wr    <= 1'b0;
            r_cfg_wr_id <= 8'd0;
            r_pending   <= INT_W'(1);
            r_enable    <= '1;
            r_int_out_n <= 1'b0;
        end else begin
            r_cmd       <= w_cmd_next;
            r_idx       <= w_idx_next;
            r_ptr       <= w_ptr_next;
            r_data_out  <= w_data_out_next;
            r_leds      <= w_leds_next;
            r_color     <= w_color_next;
            r_cfg       <= w_cfg_next;
            r_cfg_wr    <= w_cfg_wr_next;
            r_cfg_wr_id <= w_cfg_wr_id_next;
            r_pending   <= w_pending_next;
            r_enable    <= w_enable_next;
            r_int_out_n <= ~|(r_pending & r_enable);
        end
    end

    // Edge-detect reference; tracks the inputs through reset so no
    // spurious edge is seen when reset releases with a source held high
    always_ff @(posedge clk) begin
        r_int_q <= int_in;
    end

    assign data_out  = r_data_out;
    assign int_out_n = r_int_out_n;
    assign leds      = r_leds;
    assign color     = r_color;
    assign cfg_flat  = r_cfg;
    assign cfg_wr    = r_cfg_wr;
    assign cfg_wr_id = r_cfg_wr_id;

endmodule

// File: tb/tb_sysctrl_bank.sv
// tb_sysctrl_bank
//   Directed and randomized frames against a behavioural model of the
//   command protocol, config bank and interrupt controller.

module tb_sysctrl_bank;

    localparam int unsigned NUM_CFG = 32;
    localparam int unsigned INT_W   = 8;
    localparam int unsigned CFG_W   = NUM_CFG * 8;
    localparam logic [7:0]  CORE_ID = 8'h02;
    localparam logic [CFG_W-1:0] TB_DEF = {8{32'h1357_9BDF}};

    logic             clk;
    logic             reset;
    logic             data_in_strobe;
    logic             data_in_start;
    logic [7:0]       data_in;
    logic [7:0]       data_out;
    logic             int_out_n;
    logic [INT_W-1:0] int_in;
    logic [1:0]       buttons;
    logic [1:0]       leds;
    logic [23:0]      color;
    logic [CFG_W-1:0] cfg_flat;
    logic             cfg_wr;
    logic [7:0]       cfg_wr_id;

    sysctrl_bank #(
        .CORE_ID     (CORE_ID),
        .NUM_CFG     (NUM_CFG),
        .CFG_DEFAULT (TB_DEF),
        .INT_W       (INT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .data_out       (data_out),
        .int_out_n      (int_out_n),
        .int_in         (int_in),
        .buttons        (buttons),
        .leds           (leds),
        .color          (color),
        .cfg_flat       (cfg_flat),
        .cfg_wr         (cfg_wr),
        .cfg_wr_id      (cfg_wr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Behavioural model state
    int          m_cmd;
    int          m_k;
    int          m_ptr;
    logic [7:0]  m_slot [NUM_CFG];
    logic [7:0]  m_dout;
    logic [1:0]  m_leds;
    logic [23:0] m_color;
    logic [7:0]  m_pending;
    logic [7:0]  m_enable;
    int          exp_ids[$];
    int          got_ids[$];

    // Collect write pulses mid-cycle
    always @(posedge clk) begin
        #2;
        if (cfg_wr === 1'b1) got_ids.push_back(int'(cfg_wr_id));
    end

    task automatic chk(input string tag, input logic [CFG_W-1:0] obs,
                       input logic [CFG_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CFG_W-1:0] model_bank();
        logic [CFG_W-1:0] v;
        for (int s = 0; s < int'(NUM_CFG); s++) v[s*8 +: 8] = m_slot[s];
        return v;
    endfunction

    function automatic logic [7:0] model_slot(input int a);
        return (a < int'(NUM_CFG)) ? m_slot[a] : 8'h00;
    endfunction

    task automatic model_reset();
        logic [CFG_W-1:0] def_v;
        def_v = TB_DEF;
        for (int s = 0; s < int'(NUM_CFG); s++) m_slot[s] = def_v[s*8 +: 8];
        m_cmd = 0; m_k = 0; m_ptr = 0;
        m_dout = 8'h00; m_leds = 2'b00; m_color = 24'h0;
        m_pending = 8'h01; m_enable = 8'hFF;
        exp_ids.delete();
        got_ids.delete();
    endtask

    // Protocol rules applied to one received byte
    task automatic mdl(input bit st, input logic [7:0] d);
        logic [7:0] rev;
        int rd;
        if (st) begin
            m_cmd = int'(d);
            m_k = 1;
            return;
        end
        if (m_k == 0) return;
        rev = {<<{d}};
        if (m_cmd == 0) begin
            m_dout = (m_k == 1) ? 8'h5C : (m_k == 2) ? 8'h42 :
                     (m_k == 3) ? CORE_ID : (m_k == 4) ? 8'(NUM_CFG) : 8'h00;
        end else if (m_cmd == 1) begin
            if (m_k == 1) m_leds = d[1:0];
        end else if (m_cmd == 2) begin
            if (m_k == 1) m_color[15:8] = rev;
            if (m_k == 2) m_color[7:0] = rev;
            if (m_k == 3) m_color[23:16] = rev;
        end else if (m_cmd == 3) begin
            m_dout = {6'b0, buttons};
        end else if (m_cmd == 4) begin
            if (m_k == 1) m_ptr = int'(d);
            else begin
                if (m_ptr < int'(NUM_CFG)) begin
                    m_slot[m_ptr] = d;
                    exp_ids.push_back(m_ptr);
                end
                m_ptr = (m_ptr < 255) ? m_ptr + 1 : 255;
            end
        end else if (m_cmd == 5) begin
            m_dout = m_pending;
            if (m_k == 1) m_pending = m_pending & ~d;
            if (m_k == 2) m_enable = d | 8'h01;
        end
`ifdef SYSCTRL_READBACK_EN
        else if (m_cmd == 6) begin
            if (m_k == 1) begin
                m_ptr = int'(d);
                rd = m_ptr;
            end else begin
                rd = m_ptr + 1;
                m_ptr = (m_ptr < 255) ? m_ptr + 1 : 255;
            end
            m_dout = model_slot(rd);
        end
`endif
        if (m_k < 255) m_k++;
    endtask

    // One strobe, called and returning on a falling edge
    task automatic send(input bit st, input logic [7:0] d);
        data_in_strobe = 1'b1;
        data_in_start  = st;
        data_in        = d;
        mdl(st, d);
        @(negedge clk);
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        chk("data_out", CFG_W'(data_out), CFG_W'(m_dout));
        chk("leds", CFG_W'(leds), CFG_W'(m_leds));
        chk("color", CFG_W'(color), CFG_W'(m_color));
        chk("cfg_flat", cfg_flat, model_bank());
    endtask

    task automatic check_ids();
        chk("wr_count", CFG_W'(got_ids.size()), CFG_W'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < got_ids.size(); i++)
            chk("wr_id", CFG_W'(got_ids[i]), CFG_W'(exp_ids[i]));
        got_ids.delete();
        exp_ids.delete();
    endtask

    task automatic check_irq();
        @(negedge clk);
        chk("int_out_n", CFG_W'(int_out_n), CFG_W'(~|(m_pending & m_enable)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prev;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        data_in = 8'h00;
        int_in  = '0;
        buttons = 2'b00;
        @(negedge clk);
        do_reset();

        // Reset values
        chk("rst_data_out", CFG_W'(data_out), CFG_W'(8'h00));
        chk("rst_leds", CFG_W'(leds), CFG_W'(2'b00));
        chk("rst_color", CFG_W'(color), CFG_W'(24'h0));
        chk("rst_cfg", cfg_flat, TB_DEF);
        chk("rst_cfg_wr", CFG_W'(cfg_wr), CFG_W'(1'b0));
        chk("rst_cfg_wr_id", CFG_W'(cfg_wr_id), CFG_W'(8'h00));
        chk("rst_int_out_n", CFG_W'(int_out_n), CFG_W'(1'b0));

        // Payload before any command byte is ignored
        send(1'b0, 8'h01);

        // Status sequence
        send(1'b1, 8'h00);
        send(1'b0, 8'($urandom)); chk("status1", CFG_W'(data_out), CFG_W'(8'h5C));
        send(1'b0, 8'($urandom)); chk("status2", CFG_W'(data_out), CFG_W'(8'h42));
        send(1'b0, 8'($urandom)); chk("status3", CFG_W'(data_out), CFG_W'(8'h02));
        send(1'b0, 8'($urandom)); chk("status4", CFG_W'(data_out), CFG_W'(8'h20));
        send(1'b0, 8'($urandom)); chk("status5", CFG_W'(data_out), CFG_W'(8'h00));
        check_irq();

        // Coldboot acknowledge
        send(1'b1, 8'h05);
        send(1'b0, 8'h01);
        check_irq();
        chk("coldboot_irq", CFG_W'(int_out_n), CFG_W'(1'b1));
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        chk("coldboot_pend", CFG_W'(data_out), CFG_W'(8'h00));

        // Burst write across the end of the bank
        send(1'b1, 8'h04);
        send(1'b0, 8'h1E);
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        send(1'b0, 8'hCC);
        chk("slot30", CFG_W'(cfg_flat[247:240]), CFG_W'(8'hAA));
        chk("slot31", CFG_W'(cfg_flat[255:248]), CFG_W'(8'hBB));
        chk("burst_pulses", CFG_W'(got_ids.size()), CFG_W'(2));
        check_ids();

        // Config readback
        prev = m_dout;
        send(1'b1, 8'h06);
        send(1'b0, 8'h1E);
`ifdef SYSCTRL_READBACK_EN
        chk("rb0", CFG_W'(data_out), CFG_W'(8'hAA));
        send(1'b0, 8'h00);
        chk("rb1", CFG_W'(data_out), CFG_W'(8'hBB));
        send(1'b0, 8'h00);
        chk("rb2", CFG_W'(data_out), CFG_W'(8'h00));
`else
        chk("rb_off", CFG_W'(data_out), CFG_W'(prev));
        send(1'b0, 8'h00);
        chk("rb_off2", CFG_W'(data_out), CFG_W'(prev));
`endif

        // Pointer saturation: nothing lands, no pulses
        send(1'b1, 8'h04);
        send(1'b0, 8'hFE);
        for (int j = 0; j < 4; j++) send(1'b0, 8'($urandom));
        check_ids();

        // Byte index saturation on a long buttons frame
        send(1'b1, 8'h03);
        for (int j = 0; j < 262; j++) begin
            if (j >= 250) buttons = 2'($urandom);
            send(1'b0, 8'($urandom));
        end

        // Randomized frames
        for (int it = 0; it < 60; it++) begin
            int sel;
            int n;
            logic [7:0] cmd;
            logic [7:0] b;
            sel = int'($urandom_range(0, 7));
            cmd = (sel == 7) ? 8'($urandom_range(7, 255)) : 8'(sel);
            buttons = 2'($urandom);
            n = int'($urandom_range(0, 6));
            send(1'b1, cmd);
            for (int j = 0; j < n; j++) begin
                if (j == 0 && (cmd == 8'h04 || cmd == 8'h06))
                    b = 8'($urandom_range(0, 40));
                else
                    b = 8'($urandom);
                send(1'b0, b);
            end
            check_ids();
        end
        check_irq();

        // Interrupt latency: request appears two cycles after the rise
        send(1'b1, 8'h05);
        send(1'b0, 8'hFF);
        send(1'b0, 8'hFF);
        check_irq();
        int_in = 8'h08;
        @(negedge clk);
        chk("irq_lat1", CFG_W'(int_out_n), CFG_W'(1'b1));
        @(negedge clk);
        chk("irq_lat2", CFG_W'(int_out_n), CFG_W'(1'b0));
        m_pending = m_pending | 8'h08;
        int_in = 8'h00;

        // Interrupt mask
        send(1'b1, 8'h05);
        send(1'b0, 8'hFF);
        send(1'b0, 8'h03);
        int_in = 8'h04;
        @(negedge clk);
        int_in = 8'h00;
        m_pending = m_pending | 8'h04;
        repeat (2) @(negedge clk);
        chk("mask_irq", CFG_W'(int_out_n), CFG_W'(1'b1));
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        chk("mask_pend", CFG_W'(data_out), CFG_W'(8'h04));
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        send(1'b0, 8'h07);
        check_irq();
        chk("unmask_irq", CFG_W'(int_out_n), CFG_W'(1'b0));

        // Set and acknowledge of the same channel in one cycle
        send(1'b1, 8'h05);
        send(1'b0, 8'hFF);
        send(1'b1, 8'h05);
        int_in = 8'h02;
        send(1'b0, 8'h02);
        m_pending = m_pending | 8'h02;
        send(1'b1, 8'h05);
        send(1'b0, 8'h00);
        chk("collide_pend1", CFG_W'(data_out[1]), CFG_W'(1'b1));
        int_in = 8'h00;
        check_irq();

        // Mid-frame abort keeps earlier writes
        send(1'b1, 8'h04);
        send(1'b0, 8'h05);
        send(1'b0, 8'h77);
        send(1'b1, 8'h00);
        send(1'b0, 8'h00);
        chk("abort_status", CFG_W'(data_out), CFG_W'(8'h5C));
        chk("abort_slot5", CFG_W'(cfg_flat[47:40]), CFG_W'(8'h77));
        check_ids();

        // Reset mid-frame drops the frame and restores defaults
        send(1'b1, 8'h04);
        send(1'b0, 8'h02);
        do_reset();
        send(1'b0, 8'h99);
        chk("rst_mid_cfg", cfg_flat, TB_DEF);
        chk("rst_mid_dout", CFG_W'(data_out), CFG_W'(8'h00));
        check_ids();
        check_irq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
